// File: rtl/instr_prefetch_fetcher.sv
// Fetch side of the instruction realign buffer: word fetches on req/gnt/rvalid, in-order response FIFO.
// rvalid at N reaches buf_write_o at N+1; issue stalls once in-flight + buffered reaches RESP_DEPTH, drain waits on buf_full_i.

module instr_prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clr,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_dat,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_dat,
  output logic                         o_vld,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && i_push && !i_clr) r_mem[r_wr_ptr] <= i_dat;
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_vld   = (r_count != '0);
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_clr && !w_pop && (r_count == CW'(DEPTH))));
endmodule

module instr_prefetch_fetcher #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    RESP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  output logic                  buf_write_o,
  output logic [DATA_WIDTH-1:0] buf_instr_o,
  output logic [ADDR_WIDTH-1:0] buf_addr_o,
  input  logic                  buf_full_i,
  output logic                  buf_flush_o,
  output logic                  busy_o
);
  localparam int CW  = $clog2(RESP_DEPTH + 2);
  localparam int FCW = $clog2(RESP_DEPTH + 1);
  localparam int SW  = CW + 1;
  localparam logic [ADDR_WIDTH-1:0] PC0  = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
  localparam logic [ADDR_WIDTH-1:0] WORD = ADDR_WIDTH'(4);

  typedef enum logic {S_IDLE, S_REQ} state_t;
  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0]            r_addr;
  logic [ADDR_WIDTH-1:0]            r_fetch_pc;
  logic [ADDR_WIDTH-1:0]            r_rsp_pc;
  logic [ADDR_WIDTH-1:0]            w_fetch_pc_nxt;
  logic [ADDR_WIDTH-1:0]            w_target;
  logic [CW-1:0]                    r_outstanding;
  logic [CW-1:0]                    r_discard;
  logic [CW-1:0]                    w_outstanding_nxt;
  logic                             r_stale;
  logic                             r_flush;
  logic                             w_gnt;
  logic                             w_rsp;
  logic                             w_drop;
  logic                             w_push;
  logic                             w_can_issue;
  logic                             w_load_addr;
  logic [SW-1:0]                    w_inflight;
  logic [FCW-1:0]                   w_fifo_count;
  logic                             w_fifo_vld;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] w_fifo_dat;

  assign w_target = {branch_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign w_gnt    = (r_state == S_REQ) && instr_gnt_i;
  // Responses with nothing outstanding belong to grants from before reset.
  assign w_rsp    = instr_rvalid_i && (r_outstanding != '0);
  assign w_drop   = w_rsp && (r_discard != '0);
  assign w_push   = w_rsp && !w_drop && !branch_i;

  assign w_inflight        = SW'(r_outstanding) + SW'(w_fifo_count) + SW'(w_gnt);
  assign w_can_issue       = w_inflight < SW'(RESP_DEPTH);
  assign w_outstanding_nxt = r_outstanding + CW'(w_gnt) - CW'(w_rsp);

  // A stale grant already had its address replaced by the branch target.
  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    if (w_gnt && !r_stale) w_fetch_pc_nxt = r_fetch_pc + WORD;
    if (branch_i)          w_fetch_pc_nxt = w_target;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_addr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_can_issue) begin
          w_state_nxt = S_REQ;
          w_load_addr = 1'b1;
        end
      end
      S_REQ: begin
        if (instr_gnt_i) begin
          if (w_can_issue) w_load_addr = 1'b1;
          else             w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_addr        <= PC0;
      r_fetch_pc    <= PC0;
      r_rsp_pc      <= PC0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_stale       <= 1'b0;
      r_flush       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_flush       <= branch_i;
      if (w_load_addr) r_addr <= w_fetch_pc_nxt;

      if (branch_i)    r_rsp_pc <= w_target;
      else if (w_push) r_rsp_pc <= r_rsp_pc + WORD;

      // After a branch every response still owed is stale.
      if (branch_i) r_discard <= w_outstanding_nxt;
      else          r_discard <= r_discard + CW'(w_gnt && r_stale) - CW'(w_drop);

      if (branch_i && (r_state == S_REQ) && !instr_gnt_i) r_stale <= 1'b1;
      else if (w_gnt)                                      r_stale <= 1'b0;
    end
  end

  instr_prefetch_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (branch_i),
    .i_push  (w_push),
    .i_dat   ({instr_rdata_i, r_rsp_pc}),
    .i_pop   (buf_write_o),
    .o_dat   (w_fifo_dat),
    .o_vld   (w_fifo_vld),
    .o_count (w_fifo_count)
  );

  assign instr_req_o  = (r_state == S_REQ);
  assign instr_addr_o = r_addr;
  assign buf_write_o  = w_fifo_vld && !buf_full_i && !branch_i;
  assign buf_instr_o  = w_fifo_dat[ADDR_WIDTH +: DATA_WIDTH];
  assign buf_addr_o   = w_fifo_dat[ADDR_WIDTH-1:0];
  assign buf_flush_o  = r_flush;
  assign busy_o       = (r_outstanding != '0) || w_fifo_vld;
endmodule

// File: tb/tb_instr_prefetch_fetcher.sv
// Random bus/buffer stimulus against a stream model: after each reset or branch the buffer
// must see consecutive words from the target; responses to older requests never reach it.
module tb_instr_prefetch_fetcher;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        buf_write_o;
  logic [31:0] buf_instr_o;
  logic [31:0] buf_addr_o;
  logic        buf_full_i = 1'b0;
  logic        buf_flush_o;
  logic        busy_o;

  instr_prefetch_fetcher #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_PC   (RPC),
    .RESP_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .buf_write_o    (buf_write_o),
    .buf_instr_o    (buf_instr_o),
    .buf_addr_o     (buf_addr_o),
    .buf_full_i     (buf_full_i),
    .buf_flush_o    (buf_flush_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] addr; logic [31:0] data;} exp_t;
  typedef struct {logic [31:0] addr; int epoch; int ready;} mreq_t;

  exp_t  sb_q[$];
  mreq_t mem_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    n_writes = 0;
  int    cyc = 0;
  int    cur_epoch = 0;
  int    req_epoch = 0;
  int    full_mode = 0;
  logic [31:0] exp_req_pc = RPC & 32'hFFFF_FFFC;
  logic [31:0] prev_addr = '0;
  logic        prev_pend = 1'b0;
  logic        prev_branch = 1'b0;
  logic        do_push;
  logic        do_clear;
  exp_t        push_e;
  exp_t        mon_e;
  mreq_t       m;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    branch_i = 1'b0;
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0;
    buf_full_i = 1'b0;
    @(negedge clk);
    #1;
    check("reset_req",   32'(instr_req_o), 32'd0);
    check("reset_addr",  instr_addr_o, RPC & 32'hFFFF_FFFC);
    check("reset_write", 32'(buf_write_o), 32'd0);
    check("reset_flush", 32'(buf_flush_o), 32'd0);
    check("reset_busy",  32'(busy_o), 32'd0);
    sb_q.delete();
    mem_q.delete();
    cur_epoch++;
    exp_req_pc = RPC & 32'hFFFF_FFFC;
    prev_pend = 1'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: every buffer write must match the head of the expected stream.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      check("flush_pulse", 32'(buf_flush_o), 32'(prev_branch));
      check("write_when_ready", 32'(buf_write_o),
            32'((sb_q.size() > 0) && !buf_full_i && !branch_i));
      if (buf_write_o) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL buf_write_unexpected: addr %h data %h, nothing expected", buf_addr_o, buf_instr_o);
        end else begin
          mon_e = sb_q.pop_front();
          check("buf_addr", buf_addr_o, mon_e.addr);
          check("buf_instr", buf_instr_o, mon_e.data);
          n_writes++;
        end
      end
    end
    prev_branch = branch_i && rst_n;
  end

  initial begin
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      cyc++;
      if (c == 1500 || c == 2800) begin
        do_reset();
        continue;
      end
      if (c % 100 == 0) full_mode = $urandom_range(0, 2);
      case (full_mode)
        0:       buf_full_i = 1'b0;
        1:       buf_full_i = ($urandom_range(0, 99) < 35);
        default: buf_full_i = ((c % 100) < 30);
      endcase
      branch_i = ($urandom_range(0, 99) < 4);
      case ($urandom_range(0, 3))
        0:       branch_addr_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 7) * 2);
        1:       branch_addr_i = 32'h0000_0106;
        default: branch_addr_i = $urandom() & 32'hFFFF_FFFE;
      endcase
      instr_gnt_i = instr_req_o && ($urandom_range(0, 99) < 60);
      instr_rvalid_i = (mem_q.size() > 0) && (mem_q[0].ready <= cyc) && ($urandom_range(0, 99) < 70);
      instr_rdata_i = instr_rvalid_i ? mem_word(mem_q[0].addr) : $urandom();
      #1;
      do_push = 1'b0;
      do_clear = 1'b0;
      check("busy", 32'(busy_o), 32'((mem_q.size() > 0) || (sb_q.size() > 0)));

      // Request side: a pending request is held; a new one continues the current stream.
      if (prev_pend) begin
        check("req_held", 32'(instr_req_o), 32'd1);
        check("addr_held", instr_addr_o, prev_addr);
      end else if (instr_req_o) begin
        req_epoch = cur_epoch;
        check("req_addr", instr_addr_o, exp_req_pc);
        exp_req_pc = exp_req_pc + 32'd4;
      end

      if (instr_rvalid_i) begin
        m = mem_q.pop_front();
        if (m.epoch == cur_epoch && !branch_i) begin
          push_e.addr = m.addr;
          push_e.data = mem_word(m.addr);
          do_push = 1'b1;
        end
      end
      if (instr_req_o && instr_gnt_i) begin
        m.addr = instr_addr_o;
        m.epoch = req_epoch;
        m.ready = cyc + 1 + int'($urandom_range(0, 2));
        mem_q.push_back(m);
      end
      if (branch_i) begin
        cur_epoch++;
        exp_req_pc = branch_addr_i & 32'hFFFF_FFFC;
        do_clear = 1'b1;
      end
      prev_pend = instr_req_o && !instr_gnt_i;
      prev_addr = instr_addr_o;

      #2;
      if (do_clear) sb_q.delete();
      if (do_push) sb_q.push_back(push_e);
      check("resp_cap", 32'((mem_q.size() + sb_q.size()) <= DEPTH), 32'd1);
    end
    #3;
    check("writes_seen", 32'(n_writes > 100), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
